// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-requester (CORE/DMA) arbiter for the single-port data memory
//
// Purpose: grants at most one CORE or DMA access per cycle, drives the memory pins,
// registers the read data back to the winner and flags misaligned, out-of-range or
// illegal-size accesses with an error response.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   c_req_* / c_resp_*         CORE request (valid/ready/we/size/addr/wdata) and response
//   d_req_* / d_resp_*, d_lock DMA request and response; d_lock keeps the grant on DMA
//   mem_read/write/addr/wdata/be, mem_rdata   memory side (rdata is combinational)
module data_mem_arbiter #(
  parameter int MEM_BYTES  = 1024,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req_valid,
  output logic        c_req_ready,
  input  logic        c_req_we,
  input  logic [1:0]  c_req_size,
  input  logic [31:0] c_req_addr,
  input  logic [31:0] c_req_wdata,
  output logic        c_resp_valid,
  output logic [31:0] c_resp_rdata,
  output logic        c_resp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [1:0]  d_req_size,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_rdata,
  output logic        d_resp_err,
  input  logic        d_lock,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  // S_DMA mirrors S_CORE: it only records that DMA won last without locking.
  typedef enum logic [1:0] {S_IDLE, S_CORE, S_DMA, S_LOCK} state_t;

  state_t        state, state_nxt;
  logic          rr_ptr;      // 0 = CORE next on a tie, 1 = DMA next
  logic [WW-1:0] wait_cnt;

  logic          grant_c, grant_d, any_grant, dma_first;
  logic          sel_we;
  logic [1:0]    sel_size;
  logic [31:0]   sel_addr, sel_wdata;
  logic [2:0]    nbytes;
  logic [3:0]    be;
  logic [32:0]   end_addr;
  logic          err;
  logic [31:0]   rd_masked;

  // Arbitration. Grants are gated by rst_n so every output is 0 while reset is held.
  always_comb begin
    grant_c   = 1'b0;
    grant_d   = 1'b0;
    dma_first = 1'b0;
    if (rst_n) begin
      if (state == S_LOCK) begin
        grant_d = d_req_valid;
      end else if (c_req_valid && d_req_valid) begin
        if (FIXED_PRIO != 0) dma_first = (wait_cnt == WAIT_MAX);
        else                 dma_first = rr_ptr;
        grant_d = dma_first;
        grant_c = !dma_first;
      end else begin
        grant_c = c_req_valid;
        grant_d = d_req_valid;
      end
    end
  end

  assign any_grant   = grant_c | grant_d;
  assign c_req_ready = grant_c;
  assign d_req_ready = grant_d;

  // Granted request and its legality checks.
  always_comb begin
    sel_we    = grant_d ? d_req_we    : c_req_we;
    sel_size  = grant_d ? d_req_size  : c_req_size;
    sel_addr  = grant_d ? d_req_addr  : c_req_addr;
    sel_wdata = grant_d ? d_req_wdata : c_req_wdata;
    nbytes    = 3'd0;
    be        = 4'b0000;
    case (sel_size)
      2'd0: begin nbytes = 3'd1; be = 4'b0001; end
      2'd1: begin nbytes = 3'd2; be = 4'b0011; end
      2'd2: begin nbytes = 3'd4; be = 4'b1111; end
      default: begin nbytes = 3'd0; be = 4'b0000; end
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap into range.
    end_addr = {1'b0, sel_addr} + {30'd0, nbytes};
    err = (sel_size == 2'd3)
       || (sel_size == 2'd1 && sel_addr[0])
       || (sel_size == 2'd2 && sel_addr[1:0] != 2'b00)
       || (end_addr > MEM_LIMIT);
    rd_masked = mem_rdata & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  assign mem_read  = any_grant & ~sel_we & ~err;
  assign mem_write = any_grant &  sel_we & ~err;
  assign mem_addr  = any_grant ? sel_addr  : 32'd0;
  assign mem_wdata = any_grant ? sel_wdata : 32'd0;
  assign mem_be    = any_grant ? be        : 4'b0000;

  always_comb begin
    state_nxt = state;
    if (state == S_LOCK) begin
      // Lock ends on an unlocked DMA beat or on any cycle DMA drops valid.
      if ((grant_d && !d_lock) || !d_req_valid) state_nxt = S_IDLE;
    end else begin
      if (grant_d)      state_nxt = d_lock ? S_LOCK : S_DMA;
      else if (grant_c) state_nxt = S_CORE;
      else              state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= 1'b0;
      wait_cnt     <= '0;
      c_resp_valid <= 1'b0;
      c_resp_rdata <= 32'd0;
      c_resp_err   <= 1'b0;
      d_resp_valid <= 1'b0;
      d_resp_rdata <= 32'd0;
      d_resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_c)      rr_ptr <= 1'b1;
      else if (grant_d) rr_ptr <= 1'b0;
      if (grant_d)                                 wait_cnt <= '0;
      else if (d_req_valid && wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      c_resp_valid <= grant_c;
      c_resp_err   <= grant_c & err;
      c_resp_rdata <= (grant_c && !err && !sel_we) ? rd_masked : 32'd0;
      d_resp_valid <= grant_d;
      d_resp_err   <= grant_d & err;
      d_resp_rdata <= (grant_d && !err && !sel_we) ? rd_masked : 32'd0;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;

  localparam int MEMB = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        c_req_valid, c_req_ready, c_req_we, c_resp_valid, c_resp_err;
  logic [1:0]  c_req_size;
  logic [31:0] c_req_addr, c_req_wdata, c_resp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we, d_resp_valid, d_resp_err, d_lock;
  logic [1:0]  d_req_size;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        f_c_valid, f_c_ready, f_c_rv, f_c_err, f_d_valid, f_d_ready, f_d_rv, f_d_err;
  logic [31:0] f_c_rdata, f_d_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
  logic        f_mem_read, f_mem_write;
  logic [3:0]  f_mem_be;

  data_mem_arbiter #(.MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_size(c_req_size), .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
    .c_resp_valid(c_resp_valid), .c_resp_rdata(c_resp_rdata), .c_resp_err(c_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_size(d_req_size), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
    .d_lock(d_lock),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  data_mem_arbiter #(.MEM_BYTES(MEMB), .FIXED_PRIO(1), .MAX_WAIT(3)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .c_req_valid(f_c_valid), .c_req_ready(f_c_ready), .c_req_we(1'b0),
    .c_req_size(2'd2), .c_req_addr(32'd0), .c_req_wdata(32'd0),
    .c_resp_valid(f_c_rv), .c_resp_rdata(f_c_rdata), .c_resp_err(f_c_err),
    .d_req_valid(f_d_valid), .d_req_ready(f_d_ready), .d_req_we(1'b0),
    .d_req_size(2'd2), .d_req_addr(32'd4), .d_req_wdata(32'd0),
    .d_resp_valid(f_d_rv), .d_resp_rdata(f_d_rdata), .d_resp_err(f_d_err),
    .d_lock(1'b0),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_be(f_mem_be), .mem_rdata(f_mem_rdata)
  );

  // Memory seen by the DUT, plus an independent reference copy for expectations.
  logic [7:0] mem [0:MEMB-1];
  logic [7:0] ref_mem [0:MEMB-1];

  always_comb begin
    mem_rdata = 32'd0;
    for (int i = 0; i < 4; i++)
      if (longint'(mem_addr) + i < MEMB) mem_rdata[8*i +: 8] = mem[mem_addr[9:0] + 10'(i)];
  end

  always @(posedge clk)
    if (mem_write)
      for (int i = 0; i < 4; i++)
        if (mem_be[i] && longint'(mem_addr) + i < MEMB) mem[mem_addr[9:0] + 10'(i)] <= mem_wdata[8*i +: 8];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic exp_resp(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
    int nb;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    rdata = 32'd0;
    err = (nb == 0) || (addr % nb != 0) || (longint'(addr) + nb > MEMB);
    if (!err)
      for (int i = 0; i < nb; i++)
        if (we) ref_mem[addr + i] = wdata[8*i +: 8];
        else    rdata[8*i +: 8] = ref_mem[addr + i];
  endtask

  // Scoreboard: push on acceptance, pop when the response pulse appears.
  logic [32:0] c_q[$], d_q[$];
  logic        c_pend = 1'b0, d_pend = 1'b0;

  always @(negedge clk) begin
    logic        er;
    logic [31:0] rd;
    logic [32:0] e;
    if (!rst_n) begin
      check("c_resp_valid_in_reset", 32'(c_resp_valid), 32'd0);
      check("d_resp_valid_in_reset", 32'(d_resp_valid), 32'd0);
      c_pend = 1'b0; d_pend = 1'b0;
      c_q.delete(); d_q.delete();
    end else begin
      if (c_pend || c_resp_valid) begin
        check("c_resp_valid", 32'(c_resp_valid), 32'(c_pend));
        if (c_pend && c_q.size() > 0) begin
          e = c_q.pop_front();
          check("c_resp_rdata", c_resp_rdata, e[31:0]);
          check("c_resp_err", 32'(c_resp_err), 32'(e[32]));
        end
      end
      if (d_pend || d_resp_valid) begin
        check("d_resp_valid", 32'(d_resp_valid), 32'(d_pend));
        if (d_pend && d_q.size() > 0) begin
          e = d_q.pop_front();
          check("d_resp_rdata", d_resp_rdata, e[31:0]);
          check("d_resp_err", 32'(d_resp_err), 32'(e[32]));
        end
      end
      c_pend = c_req_valid && c_req_ready;
      if (c_pend) begin
        exp_resp(c_req_we, c_req_size, c_req_addr, c_req_wdata, er, rd);
        c_q.push_back({er, rd});
      end
      d_pend = d_req_valid && d_req_ready;
      if (d_pend) begin
        exp_resp(d_req_we, d_req_size, d_req_addr, d_req_wdata, er, rd);
        d_q.push_back({er, rd});
      end
    end
  end

  // Present a request just after a rising edge and stop at the following falling edge.
  task automatic issue(input logic is_d, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    if (is_d) begin
      d_req_valid = 1'b1; d_req_we = we; d_req_size = size; d_req_addr = addr; d_req_wdata = wdata;
    end else begin
      c_req_valid = 1'b1; c_req_we = we; c_req_size = size; c_req_addr = addr; c_req_wdata = wdata;
    end
    @(negedge clk);
  endtask

  task automatic release_req();
    @(posedge clk); #1;
    c_req_valid = 1'b0; d_req_valid = 1'b0; d_lock = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; c_req_valid = 1'b0; d_req_valid = 1'b0; d_lock = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < MEMB; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    rst_n = 1'b0;
    c_req_valid = 1'b1; c_req_we = 1'b0; c_req_size = 2'd2; c_req_addr = 32'h10; c_req_wdata = 32'd0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_size = 2'd0; d_req_addr = 32'd0; d_req_wdata = 32'd0;
    d_lock = 1'b0; f_c_valid = 1'b0; f_d_valid = 1'b0; f_mem_rdata = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_c_req_ready", 32'(c_req_ready), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_c_resp_rdata", c_resp_rdata, 32'd0);
    check("rst_state", 32'(dut.state), 32'd0);
    @(posedge clk); #1;
    c_req_valid = 1'b0; rst_n = 1'b1;

    // Word store then word load.
    issue(1'b0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    check("t1_mem_be", 32'(mem_be), 32'hF);
    check("t1_mem_write", 32'(mem_write), 32'd1);
    check("t1_c_req_ready", 32'(c_req_ready), 32'd1);
    release_req();
    issue(1'b0, 1'b0, 2'd2, 32'h10, 32'd0);
    check("t1_mem_read", 32'(mem_read), 32'd1);
    release_req();
    @(negedge clk);
    check("t1_load_rdata", c_resp_rdata, 32'hDEADBEEF);

    // Byte load, misaligned half load, illegal size.
    issue(1'b0, 1'b0, 2'd0, 32'h11, 32'd0);
    release_req();
    @(negedge clk);
    check("t2_byte_rdata", c_resp_rdata, 32'h000000BE);
    check("t2_byte_err", 32'(c_resp_err), 32'd0);
    issue(1'b0, 1'b0, 2'd1, 32'h11, 32'd0);
    check("t2_half_mem_read", 32'(mem_read), 32'd0);
    check("t2_half_ready", 32'(c_req_ready), 32'd1);
    release_req();
    @(negedge clk);
    check("t2_half_err", 32'(c_resp_err), 32'd1);
    issue(1'b1, 1'b1, 2'd3, 32'h20, 32'h12345678);
    check("t2_size3_mem_write", 32'(mem_write), 32'd0);
    release_req();

    // Range boundary on the DMA port.
    issue(1'b1, 1'b0, 2'd2, 32'(MEMB - 2), 32'd0);
    release_req();
    @(negedge clk);
    check("t3_oor_err", 32'(d_resp_err), 32'd1);
    check("t3_oor_rdata", d_resp_rdata, 32'd0);
    issue(1'b1, 1'b0, 2'd2, 32'(MEMB - 4), 32'd0);
    release_req();
    @(negedge clk);
    check("t3_last_word_err", 32'(d_resp_err), 32'd0);

    // Round-robin alternation from a fresh reset.
    pulse_reset();
    c_req_valid = 1'b1; c_req_we = 1'b0; c_req_size = 2'd2; c_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_size = 2'd0; d_req_addr = 32'h11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t4_c_grant_%0d", i), 32'(c_req_ready), 32'(i % 2 == 0));
      check($sformatf("t4_d_grant_%0d", i), 32'(d_req_ready), 32'(i % 2 == 1));
      if (i > 0) check($sformatf("t4_c_resp_%0d", i), 32'(c_resp_valid), 32'((i - 1) % 2 == 0));
    end
    release_req();

    // Fixed priority with starvation limit 3.
    @(posedge clk); #1;
    f_c_valid = 1'b1; f_d_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t5_d_grant_%0d", i), 32'(f_d_ready), 32'(i == 3));
      check($sformatf("t5_c_grant_%0d", i), 32'(f_c_ready), 32'(i != 3));
      if (i == 4) check("t5_wait_cnt_cleared", 32'(dut_fp.wait_cnt), 32'd0);
    end
    @(posedge clk); #1;
    f_c_valid = 1'b0; f_d_valid = 1'b0;

    // Locked DMA burst; a CORE access first moves rr_ptr to DMA.
    pulse_reset();
    issue(1'b0, 1'b0, 2'd0, 32'h3, 32'd0);
    @(posedge clk); #1;
    c_req_addr = 32'h20;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_size = 2'd2; d_req_addr = 32'h40; d_req_wdata = 32'hA5A5_0001;
    d_lock = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("t6_d_beat_%0d", j), 32'(d_req_ready), 32'd1);
      check($sformatf("t6_c_blocked_%0d", j), 32'(c_req_ready), 32'd0);
      @(posedge clk); #1;
      d_req_addr = d_req_addr + 32'd4;
      d_req_wdata = d_req_wdata + 32'd1;
      d_lock = (j + 1 < 2);
      if (j == 2) d_req_valid = 1'b0;
    end
    @(negedge clk);
    check("t6_c_after_burst", 32'(c_req_ready), 32'd1);
    check("t6_d_after_burst", 32'(d_req_ready), 32'd0);

    // Same burst start, reset pulsed after the first locked beat.
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_lock = 1'b1;
    @(negedge clk);
    check("t6r_d_beat0", 32'(d_req_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6r_d_resp_dropped", 32'(d_resp_valid), 32'd0);
    check("t6r_state_idle", 32'(dut.state), 32'd0);
    check("t6r_c_ready_in_reset", 32'(c_req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; d_lock = 1'b0;
    @(negedge clk);
    check("t6r_lock_released", 32'(c_req_ready), 32'd1);
    check("t6r_d_not_granted", 32'(d_req_ready), 32'd0);
    release_req();

    repeat (3) @(negedge clk);
    check("c_queue_drained", 32'(c_q.size()), 32'd0);
    check("d_queue_drained", 32'(d_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
